decode_buffer: RTL and testbench

//  Parametrised IF->ID decode stage: takes fetched (pc, instr) pairs over valid/ready,

---
 rtl/decode_buffer_pkg.sv | 60 ++++++
 rtl/decode_buffer_if.sv | 33 +++
 rtl/decode_buffer_instr_field_decode.sv | 103 ++++++++++
 rtl/decode_buffer.sv | 99 +++++++++
 tb/tb_decode_buffer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/decode_buffer_pkg.sv
// Shared types for the IF->ID decode buffer: opcode map, immediate selector,
// the decoded packet layout and the immediate builder.
// Optional feature macro: DECODE_BUFFER_ILLEGAL_CHK_EN (per-entry illegal flag).
package decode_buffer_pkg;

  localparam int DECODE_PC_W = 32;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BR     = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_FENCE  = 7'b0001111,
    OP_SYSTEM = 7'b1110011
  } rv32i_opcode_t;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_sel_t;

  typedef struct packed {
    logic [DECODE_PC_W-1:0] pc;
    logic [31:0]            instr;
    logic [6:0]             opcode;
    logic [2:0]             funct3;
    logic [6:0]             funct7;
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic [4:0]             rd;
    logic [31:0]            imm;
    logic                   rs1_used;
    logic                   rs2_used;
    logic                   rd_we;
  } decoded_pkt_t;

  // Assemble the sign-extended immediate for the chosen instruction format.
  function automatic logic [31:0] build_imm(input imm_sel_t sel, input logic [31:0] i);
    logic [31:0] imm;
    case (sel)
      IMM_I:   imm = {{20{i[31]}}, i[31:20]};
      IMM_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   imm = {i[31:12], 12'b0};
      IMM_J:   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm = 32'b0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_buffer_if.sv
// Handshake bundle between fetch, the decode buffer and the ID stage.
// slave = the buffer itself, master = the surrounding pipeline.
interface decode_buffer_if
  import decode_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [PC_W-1:0]  in_pc;
  logic [31:0]      in_instr;
  logic             out_valid;
  logic             out_ready;
  decoded_pkt_t     out_pkt;
  logic             out_illegal;
  logic [CNT_W-1:0] count;

  modport slave (
    input  flush, in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pkt, out_illegal, count
  );

  modport master (
    output flush, in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pkt, out_illegal, count
  );

endinterface

// File: rtl/decode_buffer_instr_field_decode.sv
// Purely combinational field split of one RV32I instruction word into a
// decoded packet, plus an illegal-encoding indication.
module instr_field_decode
  import decode_buffer_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [31:0]     instr,
  input  logic [PC_W-1:0] pc,
  output decoded_pkt_t    pkt,
  output logic            illegal
);

  imm_sel_t   imm_sel;
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  // Raw fields always pass through; only the used/we flags depend on opcode.
  always_comb begin
    pkt          = '0;
    imm_sel      = IMM_NONE;
    pkt.pc       = DECODE_PC_W'(pc);
    pkt.instr    = instr;
    pkt.opcode   = opc;
    pkt.rd       = instr[11:7];
    pkt.funct3   = f3;
    pkt.rs1      = instr[19:15];
    pkt.rs2      = instr[24:20];
    pkt.funct7   = f7;
    case (opc)
      OP_REG: begin
        pkt.rs1_used = 1'b1;
        pkt.rs2_used = 1'b1;
        pkt.rd_we    = 1'b1;
      end
      OP_IMM, OP_LOAD: begin
        imm_sel      = IMM_I;
        pkt.rs1_used = 1'b1;
        pkt.rd_we    = 1'b1;
      end
      OP_JALR: begin
        imm_sel      = IMM_I;
        pkt.rs1_used = 1'b1;
        pkt.rd_we    = 1'b1;
      end
      OP_STORE: begin
        imm_sel      = IMM_S;
        pkt.rs1_used = 1'b1;
        pkt.rs2_used = 1'b1;
      end
      OP_BR: begin
        imm_sel      = IMM_B;
        pkt.rs1_used = 1'b1;
        pkt.rs2_used = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        imm_sel   = IMM_U;
        pkt.rd_we = 1'b1;
      end
      OP_JAL: begin
        imm_sel   = IMM_J;
        pkt.rd_we = 1'b1;
      end
      default: begin
        imm_sel = IMM_NONE;
      end
    endcase
    // x0 is never a real destination, so suppress the write enable for it.
    if (instr[11:7] == 5'd0) begin
      pkt.rd_we = 1'b0;
    end
    pkt.imm = build_imm(imm_sel, instr);
  end

  // Flag encodings outside the RV32I base set or with reserved funct fields.
  always_comb begin
    illegal = 1'b0;
    case (opc)
      OP_REG: begin
        if (f7 != 7'h00 && f7 != 7'h20) begin
          illegal = 1'b1;
        end else if (f7 == 7'h20 && f3 != 3'b000 && f3 != 3'b101) begin
          illegal = 1'b1;
        end
      end
      OP_LOAD:  illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      OP_STORE: illegal = (f3 > 3'b010);
      OP_BR:    illegal = (f3 == 3'b010) || (f3 == 3'b011);
      OP_JALR:  illegal = (f3 != 3'b000);
      OP_LUI, OP_AUIPC, OP_JAL, OP_IMM, OP_FENCE, OP_SYSTEM: illegal = 1'b0;
      default:  illegal = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_buffer.sv
// IF->ID decode buffer: decodes each accepted fetch word and queues the
// packet in a DEPTH-entry circular FIFO toward the ID stage.
// Optional feature macro: DECODE_BUFFER_ILLEGAL_CHK_EN stores an illegal bit
// per entry; without it out_illegal is tied low.
module decode_buffer
  import decode_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input logic            clk,
  input logic            rst,
  decode_buffer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic          in_ready;
  logic          out_valid;
  logic          push;
  logic          pop;
  decoded_pkt_t  dec_pkt;
  logic          dec_illegal;
  decoded_pkt_t  mem [DEPTH];

  instr_field_decode #(
    .PC_W (PC_W)
  ) u_decode (
    .instr   (bus.in_instr),
    .pc      (bus.in_pc),
    .pkt     (dec_pkt),
    .illegal (dec_illegal)
  );

  // Readiness depends only on occupancy, never on out_ready.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = bus.in_valid & in_ready & ~bus.flush;
  assign pop       = out_valid & bus.out_ready & ~bus.flush;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.count     = count_q;
  assign bus.out_pkt   = out_valid ? mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping; flush wins over any push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Packet storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= dec_pkt;
    end
  end

`ifdef DECODE_BUFFER_ILLEGAL_CHK_EN
  logic ill_mem [DEPTH];

  // Illegal flag captured alongside each packet.
  always_ff @(posedge clk) begin
    if (push) begin
      ill_mem[wr_ptr] <= dec_illegal;
    end
  end

  assign bus.out_illegal = out_valid & ill_mem[rd_ptr];
`else
  logic unused_illegal;
  assign unused_illegal  = dec_illegal;
  assign bus.out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_decode_buffer.sv
// Directed bench for decode_buffer: reset, field decode, immediates,
// backpressure with pointer wrap, flush and the illegal flag.
module tb_decode_buffer;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  decode_buffer_if #(.DEPTH(4), .PC_W(32)) bus ();

  decode_buffer #(.DEPTH(4), .PC_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi1(input int k);
    return (32'(k) << 20) | 32'h0000_0093;
  endfunction

`ifdef DECODE_BUFFER_ILLEGAL_CHK_EN
  localparam logic ILL_EN = 1'b1;
`else
  localparam logic ILL_EN = 1'b0;
`endif

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b1;
    chk("rst_count", bus.count, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_pkt", bus.out_pkt, 0);

    // Reset mid-stream.
    bus.in_valid = 1'b1;
    bus.in_instr = addi1(7);
    step();
    step();
    chk("pre_rst_count", bus.count, 2);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_count", bus.count, 0);
    chk("async_rst_out_valid", bus.out_valid, 0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    step();
    chk("rel_out_valid", bus.out_valid, 0);
    chk("rel_count", bus.count, 0);
    chk("rel_in_ready", bus.in_ready, 1);

    // addi x1, x2, -1
    bus.in_valid = 1'b1;
    bus.in_instr = 32'hFFF1_0093;
    bus.in_pc    = 32'h40;
    step();
    bus.in_valid = 1'b0;
    chk("addi_valid", bus.out_valid, 1);
    chk("addi_pc", bus.out_pkt.pc, 32'h40);
    chk("addi_opcode", bus.out_pkt.opcode, 7'h13);
    chk("addi_rd", bus.out_pkt.rd, 1);
    chk("addi_rs1", bus.out_pkt.rs1, 2);
    chk("addi_imm", bus.out_pkt.imm, 32'hFFFF_FFFF);
    chk("addi_rs1_used", bus.out_pkt.rs1_used, 1);
    chk("addi_rs2_used", bus.out_pkt.rs2_used, 0);
    chk("addi_rd_we", bus.out_pkt.rd_we, 1);
    chk("addi_illegal", bus.out_illegal, 0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("addi_pop_count", bus.count, 0);
    chk("empty_pkt_zero", bus.out_pkt, 0);

    // sw x5, 8(x2)
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h0051_2423;
    bus.in_pc    = 32'h44;
    step();
    bus.in_valid = 1'b0;
    chk("sw_imm", bus.out_pkt.imm, 32'h8);
    chk("sw_rs1", bus.out_pkt.rs1, 2);
    chk("sw_rs2", bus.out_pkt.rs2, 5);
    chk("sw_rd_raw", bus.out_pkt.rd, 8);
    chk("sw_funct3", bus.out_pkt.funct3, 3'b010);
    chk("sw_rd_we", bus.out_pkt.rd_we, 0);
    chk("sw_rs2_used", bus.out_pkt.rs2_used, 1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // jal x0, -4
    bus.in_valid = 1'b1;
    bus.in_instr = 32'hFFDF_F06F;
    step();
    bus.in_valid = 1'b0;
    chk("jal_imm", bus.out_pkt.imm, 32'hFFFF_FFFC);
    chk("jal_rd_we", bus.out_pkt.rd_we, 0);
    chk("jal_rs1_used", bus.out_pkt.rs1_used, 0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // lui x5, 0x12345 then beq x0, x0, -4 queued together.
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h1234_52B7;
    step();
    bus.in_instr = 32'hFE00_0EE3;
    step();
    bus.in_valid = 1'b0;
    chk("lui_count", bus.count, 2);
    chk("lui_imm", bus.out_pkt.imm, 32'h1234_5000);
    chk("lui_rd_we", bus.out_pkt.rd_we, 1);
    chk("lui_rs1_used", bus.out_pkt.rs1_used, 0);
    bus.out_ready = 1'b1;
    step();
    chk("beq_imm", bus.out_pkt.imm, 32'hFFFF_FFFC);
    chk("beq_rs2_used", bus.out_pkt.rs2_used, 1);
    chk("beq_rd_we", bus.out_pkt.rd_we, 0);
    step();
    bus.out_ready = 1'b0;
    chk("beq_drained", bus.count, 0);

    // Fill to DEPTH with backpressure.
    bus.in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      bus.in_instr = addi1(k);
      step();
    end
    chk("full_count", bus.count, 4);
    chk("full_in_ready", bus.in_ready, 0);
    bus.in_instr = addi1(5);
    step();
    chk("held_count", bus.count, 4);
    chk("held_head", bus.out_pkt.imm, 1);

    // Drain while pushing; order must survive pointer wrap.
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      bus.in_instr = addi1((k == 1) ? 5 : k + 3);
      step();
      chk("wrap_head", bus.out_pkt.imm, 32'(k + 1));
      chk("wrap_count", bus.count, 3);
    end
    bus.in_valid = 1'b0;
    for (int k = 10; k <= 11; k++) begin
      step();
      chk("tail_head", bus.out_pkt.imm, 32'(k));
    end
    step();
    bus.out_ready = 1'b0;
    chk("tail_empty", bus.out_valid, 0);

    // Flush with a simultaneous push and pop.
    bus.in_valid = 1'b1;
    for (int k = 20; k <= 22; k++) begin
      bus.in_instr = addi1(k);
      step();
    end
    chk("pre_flush_count", bus.count, 3);
    chk("pre_flush_head", bus.out_pkt.imm, 20);
    bus.flush     = 1'b1;
    bus.in_instr  = addi1(30);
    bus.out_ready = 1'b1;
    step();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("flush_count", bus.count, 0);
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_in_ready", bus.in_ready, 1);
    step();
    chk("flush_stays_empty", bus.count, 0);
    bus.in_valid = 1'b1;
    bus.in_instr = addi1(40);
    step();
    bus.in_valid = 1'b0;
    chk("post_flush_head", bus.out_pkt.imm, 40);
    chk("post_flush_count", bus.count, 1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Illegal flag.
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h0000_0000;
    step();
    bus.in_instr = 32'h0000_0013;
    step();
    bus.in_instr = 32'h4000_1033;
    step();
    bus.in_valid = 1'b0;
    chk("ill_zero_word", bus.out_illegal, ILL_EN);
    chk("ill_zero_imm", bus.out_pkt.imm, 0);
    bus.out_ready = 1'b1;
    step();
    chk("nop_illegal", bus.out_illegal, 0);
    chk("nop_rd_we", bus.out_pkt.rd_we, 0);
    chk("nop_rs1_used", bus.out_pkt.rs1_used, 1);
    step();
    chk("sub_f3_illegal", bus.out_illegal, ILL_EN);
    step();
    bus.out_ready = 1'b0;
    chk("ill_empty_flag", bus.out_illegal, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
